// File: rtl/reg_memory_bank_pkg.sv
// Shared constants and helpers for the register memory bank and its button debouncer.
package reg_memory_bank_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_DEPTH    = 4;
  localparam int unsigned DEF_DEBOUNCE = 4;
  localparam int unsigned DEF_CNT_W    = 8;

  // Ceiling log2 usable in parameter expressions; returns 0 for n <= 1.
  function automatic int unsigned mem_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_memory_bank_btn_debounce.sv
// Button front end: 2-flop synchronizer, stability counter and registered rising-edge strobe.
module btn_debounce
  import reg_memory_bank_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic stable,
  output logic rise_pulse
);

  localparam int unsigned CW   = (DEBOUNCE > 1) ? mem_clog2(DEBOUNCE) : 1;
  localparam int unsigned LAST = (DEBOUNCE > 0) ? DEBOUNCE - 1 : 0;

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic          stable_prev_q;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept a level change only after it has persisted DEBOUNCE cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = stable_q & ~stable_prev_q;
    if (DEBOUNCE == 0) begin
      stable_d = s2_q;
    end else if (s2_q != stable_q) begin
      if (cnt_q == CW'(LAST)) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      rise_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      s1_q          <= btn_in;
      s2_q          <= s1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      rise_q        <= rise_d;
      cnt_q         <= cnt_d;
    end
  end

  assign stable     = stable_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/reg_memory_bank.sv
// Flip-flop word store written on debounced button presses, with registered read-out,
// per-word valid flags, clear-all and a saturating accepted-write counter.
module reg_memory_bank
  import reg_memory_bank_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEF_WIDTH,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  int unsigned DEBOUNCE = DEF_DEBOUNCE,
  parameter  int unsigned CNT_W    = DEF_CNT_W,
  localparam int unsigned ADDR_W   = mem_clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  din,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_btn,
  input  logic              clr,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic              wr_pulse,
  output logic [CNT_W-1:0]  wr_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse;
  logic             stable_unused;
  logic             addr_ok;
  logic             wr_en;
  logic [WIDTH-1:0] rd_word;
  logic             rd_valid;

  btn_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_btn (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (wr_btn),
    .stable     (stable_unused),
    .rise_pulse (pulse)
  );

  // Write, clear and read-through decisions; clear overrides any same-cycle write.
  always_comb begin
    mem_d        = mem_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    rd_word      = '0;
    rd_valid     = 1'b0;
    addr_ok      = 32'(addr) < DEPTH;
    wr_en        = pulse && !clr && addr_ok;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (32'(addr) == i) begin
        rd_word  = mem_q[i];
        rd_valid = valid_q[i];
        if (wr_en) begin
          mem_d[i]   = din;
          valid_d[i] = 1'b1;
        end
      end
    end
    if (wr_en && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    dout_d       = rd_word;
    dout_valid_d = rd_valid;
    if (wr_en) begin
      dout_d       = din;
      dout_valid_d = 1'b1;
    end
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = '0;
      valid_d      = '0;
      dout_d       = '0;
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      mem_q        <= mem_d;
      valid_q      <= valid_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign wr_pulse   = pulse;
  assign wr_count   = cnt_q;

endmodule

// File: tb/tb_reg_memory_bank.sv
// Directed bench: three instances (default, DEPTH=3, CNT_W=2) share stimulus and are checked together.
module tb_reg_memory_bank;

  logic       clk = 1'b0;
  logic       reset, wr_btn, clr;
  logic [7:0] din;
  logic [1:0] addr;

  logic [7:0] dout, dout3, doutc;
  logic       dv, dv3, dvc;
  logic       wp, wp3, wpc;
  logic [7:0] cnt, cnt3;
  logic [1:0] cntc;

  int tests = 0;
  int fails = 0;
  int last_lat = 0;

  always #5 clk = ~clk;

  reg_memory_bank #(.WIDTH(8), .DEPTH(4), .DEBOUNCE(4), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .din(din), .addr(addr), .wr_btn(wr_btn), .clr(clr),
    .dout(dout), .dout_valid(dv), .wr_pulse(wp), .wr_count(cnt));

  reg_memory_bank #(.WIDTH(8), .DEPTH(3), .DEBOUNCE(4), .CNT_W(8)) u_dut3 (
    .clk(clk), .reset(reset), .din(din), .addr(addr), .wr_btn(wr_btn), .clr(clr),
    .dout(dout3), .dout_valid(dv3), .wr_pulse(wp3), .wr_count(cnt3));

  reg_memory_bank #(.WIDTH(8), .DEPTH(4), .DEBOUNCE(4), .CNT_W(2)) u_dutc (
    .clk(clk), .reset(reset), .din(din), .addr(addr), .wr_btn(wr_btn), .clr(clr),
    .dout(doutc), .dout_valid(dvc), .wr_pulse(wpc), .wr_count(cntc));

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;  logic v;  logic [7:0] c;
    logic [7:0] d3; logic v3; logic [7:0] c3;
    logic [1:0] cc;
  } rd_vec_t;

  rd_vec_t vecs [24];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Present each address for one edge and compare the registered read-out of all instances.
  task automatic run_reads(input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      addr = vecs[k].a;
      tick;
      check($sformatf("rd%0d_dout", k),   32'(dout),  32'(vecs[k].d));
      check($sformatf("rd%0d_valid", k),  32'(dv),    32'(vecs[k].v));
      check($sformatf("rd%0d_cnt", k),    32'(cnt),   32'(vecs[k].c));
      check($sformatf("rd%0d_dout3", k),  32'(dout3), 32'(vecs[k].d3));
      check($sformatf("rd%0d_valid3", k), 32'(dv3),   32'(vecs[k].v3));
      check($sformatf("rd%0d_cnt3", k),   32'(cnt3),  32'(vecs[k].c3));
      check($sformatf("rd%0d_doutc", k),  32'(doutc), 32'(vecs[k].d));
      check($sformatf("rd%0d_validc", k), 32'(dvc),   32'(vecs[k].v));
      check($sformatf("rd%0d_cntc", k),   32'(cntc),  32'(vecs[k].cc));
    end
  endtask

  // Steady press: wait for the strobe, check the write-through cycle, hold, release.
  task automatic press(input logic [1:0] a, input logic [7:0] d, input int hold,
                       input logic [7:0] ed,  input logic ev,  input logic [7:0] ec,
                       input logic [7:0] ed3, input logic ev3, input logic [7:0] ec3,
                       input logic [1:0] ecc);
    int  n;
    int  extra;
    bit  seen;
    addr   = a;
    din    = d;
    wr_btn = 1'b1;
    n      = 0;
    seen   = 1'b0;
    while (!seen && n < 20) begin
      tick;
      n++;
      if (wp === 1'b1) seen = 1'b1;
    end
    last_lat = n;
    check("press_pulse_seen", 32'(seen), 32'd1);
    check("press_pulse3", 32'(wp3), 32'd1);
    check("press_pulsec", 32'(wpc), 32'd1);
    tick;
    check("press_pulse_width", 32'(wp), 32'd0);
    check("press_dout",  32'(dout),  32'(ed));
    check("press_valid", 32'(dv),    32'(ev));
    check("press_cnt",   32'(cnt),   32'(ec));
    check("press_dout3", 32'(dout3), 32'(ed3));
    check("press_valid3", 32'(dv3),  32'(ev3));
    check("press_cnt3",  32'(cnt3),  32'(ec3));
    check("press_cntc",  32'(cntc),  32'(ecc));
    extra = 0;
    repeat (hold) begin
      tick;
      if (wp === 1'b1) extra++;
    end
    wr_btn = 1'b0;
    repeat (10) begin
      tick;
      if (wp === 1'b1) extra++;
    end
    check("press_no_repeat", 32'(extra), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    // after reset
    for (int i = 0; i < 4; i++) vecs[i] = '{2'(i), 8'h00, 1'b0, 8'd0, 8'h00, 1'b0, 8'd0, 2'd0};
    // after 0xA5 -> addr 2
    vecs[4]  = '{2'd0, 8'h00, 1'b0, 8'd1, 8'h00, 1'b0, 8'd1, 2'd1};
    vecs[5]  = '{2'd1, 8'h00, 1'b0, 8'd1, 8'h00, 1'b0, 8'd1, 2'd1};
    vecs[6]  = '{2'd2, 8'hA5, 1'b1, 8'd1, 8'hA5, 1'b1, 8'd1, 2'd1};
    vecs[7]  = '{2'd3, 8'h00, 1'b0, 8'd1, 8'h00, 1'b0, 8'd1, 2'd1};
    // after bounced press of 0x5A -> addr 1
    vecs[8]  = '{2'd0, 8'h00, 1'b0, 8'd2, 8'h00, 1'b0, 8'd2, 2'd2};
    vecs[9]  = '{2'd1, 8'h5A, 1'b1, 8'd2, 8'h5A, 1'b1, 8'd2, 2'd2};
    vecs[10] = '{2'd2, 8'hA5, 1'b1, 8'd2, 8'hA5, 1'b1, 8'd2, 2'd2};
    vecs[11] = '{2'd3, 8'h00, 1'b0, 8'd2, 8'h00, 1'b0, 8'd2, 2'd2};
    // after reset and 0x11..0x44 -> addr 0..3 (addr 3 out of range for DEPTH=3)
    vecs[12] = '{2'd0, 8'h11, 1'b1, 8'd4, 8'h11, 1'b1, 8'd3, 2'd3};
    vecs[13] = '{2'd1, 8'h22, 1'b1, 8'd4, 8'h22, 1'b1, 8'd3, 2'd3};
    vecs[14] = '{2'd2, 8'h33, 1'b1, 8'd4, 8'h33, 1'b1, 8'd3, 2'd3};
    vecs[15] = '{2'd3, 8'h44, 1'b1, 8'd4, 8'h00, 1'b0, 8'd3, 2'd3};
    // after clr
    for (int i = 0; i < 4; i++) vecs[16+i] = '{2'(i), 8'h00, 1'b0, 8'd4, 8'h00, 1'b0, 8'd3, 2'd3};
    // after reset in the debounce window
    for (int i = 0; i < 4; i++) vecs[20+i] = '{2'(i), 8'h00, 1'b0, 8'd0, 8'h00, 1'b0, 8'd0, 2'd0};

    reset = 1'b1; wr_btn = 1'b0; clr = 1'b0; din = 8'h00; addr = 2'd0;
    repeat (3) tick;
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_valid", 32'(dv), 32'd0);
    check("reset_pulse", 32'(wp), 32'd0);
    check("reset_cnt", 32'(cnt), 32'd0);
    reset = 1'b0;
    run_reads(0, 4);

    press(2'd2, 8'hA5, 0, 8'hA5, 1'b1, 8'd1, 8'hA5, 1'b1, 8'd1, 2'd1);
    check("press_latency_6_7", 32'(last_lat >= 6 && last_lat <= 7), 32'd1);
    run_reads(4, 4);

    // bounce: high 2 / low 1, never stable long enough
    np = 0;
    repeat (4) begin
      wr_btn = 1'b1; tick; if (wp === 1'b1) np++;
      tick; if (wp === 1'b1) np++;
      wr_btn = 1'b0; tick; if (wp === 1'b1) np++;
    end
    check("bounce_no_pulse", 32'(np), 32'd0);
    press(2'd1, 8'h5A, 100, 8'h5A, 1'b1, 8'd2, 8'h5A, 1'b1, 8'd2, 2'd2);
    run_reads(8, 4);

    reset = 1'b1; repeat (2) tick; reset = 1'b0;
    press(2'd0, 8'h11, 0, 8'h11, 1'b1, 8'd1, 8'h11, 1'b1, 8'd1, 2'd1);
    press(2'd1, 8'h22, 0, 8'h22, 1'b1, 8'd2, 8'h22, 1'b1, 8'd2, 2'd2);
    press(2'd2, 8'h33, 0, 8'h33, 1'b1, 8'd3, 8'h33, 1'b1, 8'd3, 2'd3);
    press(2'd3, 8'h44, 0, 8'h44, 1'b1, 8'd4, 8'h00, 1'b0, 8'd3, 2'd3);
    run_reads(12, 4);

    clr = 1'b1; tick; clr = 1'b0;
    run_reads(16, 4);

    // clr held across the strobe: write dropped and not counted
    clr = 1'b1;
    press(2'd0, 8'h77, 0, 8'h00, 1'b0, 8'd4, 8'h00, 1'b0, 8'd3, 2'd3);
    clr = 1'b0;
    run_reads(16, 4);

    // fifth accepted write saturates the 2-bit counter
    press(2'd1, 8'h99, 0, 8'h99, 1'b1, 8'd5, 8'h99, 1'b1, 8'd4, 2'd3);

    // reset mid-debounce with the button released during reset
    addr = 2'd0; din = 8'hEE; wr_btn = 1'b1;
    repeat (4) tick;
    reset = 1'b1; wr_btn = 1'b0;
    repeat (2) tick;
    reset = 1'b0;
    np = 0;
    repeat (20) begin
      tick;
      if (wp === 1'b1) np++;
    end
    check("rst_debounce_no_pulse", 32'(np), 32'd0);
    run_reads(20, 4);

    // out-of-range address for DEPTH=3: strobe still fires, nothing stored or counted there
    press(2'd3, 8'hC3, 0, 8'hC3, 1'b1, 8'd1, 8'h00, 1'b0, 8'd0, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_memory_bank.md
Name: reg_memory_bank

Overview:
- Clocked, parametrised successor to the team's four-byte latch memory.
- Holds DEPTH words of WIDTH bits in flip-flops; the selected word is written on a debounced, edge-detected button press.
- Read-out is registered and includes a per-word valid flag.
- Sits between board switches/button and LEDs. Adds a clear-all control and a saturating write counter.

Parameters:
- WIDTH, 8, data bits per word.
- DEPTH, 4, number of words; need not be a power of two; minimum 2.
- ADDR_W, clog2(DEPTH), address width; derived, not overridden.
- DEBOUNCE, 4, consecutive stable cycles required before a button change is accepted; 0 bypasses debounce.
- CNT_W, 8, width of the write counter.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  write data.
- addr  input  ADDR_W  shared read/write address.
- wr_btn  input  1  raw asynchronous write button.
- clr  input  1  synchronous clear-all; level, sampled each cycle.
- dout  output  WIDTH  registered read data.
- dout_valid  output  1  registered valid flag of the addressed word.
- wr_pulse  output  1  one-cycle strobe: a write is attempted this cycle.
- wr_count  output  CNT_W  number of accepted writes, saturating.

Behaviour:
- Reset values: all words 0, all valid bits 0, dout 0, dout_valid 0, wr_pulse 0, wr_count 0. Synchronizer, debounce counter and stable state also clear to 0.
- Input path:
  - wr_btn passes through a 2-flop synchronizer (s1, s2).
  - With DEBOUNCE>0, a counter increments while s2 != stable and resets to 0 whenever s2 == stable.
  - When the counter reaches DEBOUNCE-1 while s2 still differs, stable <= s2 and the counter clears. With DEBOUNCE=0, stable <= s2 every cycle.
- wr_pulse is registered and equals the rising edge of stable (stable & ~stable_d). It is high exactly one cycle per accepted press; holding the button produces no further pulses, and bounces shorter than DEBOUNCE cycles produce no pulse.
- Write: on a clk edge where wr_pulse=1, clr=0 and addr<DEPTH:
  - mem[addr] <= din and valid[addr] <= 1.
  - wr_count increments, holding at 2^CNT_W-1.
- Ignored writes: if addr>=DEPTH, the write is dropped and wr_count is unchanged; wr_pulse still asserts.
- clr=1: all words <= 0 and all valid <= 0. wr_count is preserved. clr has priority over a simultaneous write: the write is dropped and not counted.
- Read (1-cycle latency): dout <= word at the current addr, dout_valid <= its valid bit.
  - Write-through: if a write to the same addr occurs on that edge, dout takes din and dout_valid takes 1.
  - If clr is also asserted on that edge, dout takes 0 and dout_valid takes 0.
  - addr>=DEPTH gives dout=0 and dout_valid=0.
- reset has priority over everything. Asserting reset mid-debounce discards the pending press; the button must go low and high again, debounced, to write.
- No latches; all state changes on rising clk.

Decomposition:
- Shared package/include holds: clog2 constant function for ADDR_W, default WIDTH/DEPTH/DEBOUNCE/CNT_W constants.
- One sub-module: btn_debounce, parameter DEBOUNCE. It contains the synchronizer, stable counter and rising-edge detector, with ports clk, reset, btn_in, stable, rise_pulse.
- Top-level reg_memory_bank holds the storage array, valid vector, read register and counter.

Test Plan (WIDTH=8, DEPTH=4, DEBOUNCE=4, CNT_W=8 unless noted):
- Reset, then read addr 0..3 -> dout=0x00, dout_valid=0, wr_count=0.
- din=0xA5, addr=2, wr_btn high 10 cycles -> one wr_pulse roughly 6–7 cycles after the press. Next cycle: dout=0xA5, dout_valid=1, wr_count=1. Addr 0, 1, 3 remain 0 and invalid.
- Button bounce of high 2 cycles / low 1 cycle repeated, then steady high -> exactly one wr_pulse, wr_count +1. Holding high 100 cycles -> no second pulse.
- Write 0x11..0x44 into addr 0..3, then clr for 1 cycle -> all reads give 0x00, dout_valid=0; wr_count stays 4. With wr_pulse and clr asserted together -> no write, count unchanged.
- DEPTH=3, addr=3, press -> wr_pulse=1, wr_count unchanged, dout=0, dout_valid=0.
- CNT_W=2, 5 accepted writes -> wr_count=3 (saturated). Reset asserted during the debounce window -> no write, wr_count=0.
